alu_cmd_issue: RTL and testbench

Command-issue stage that sits directly upstream of the 4-bit accumulator ALU (accum5) and feeds its a/b/cin/m operand inputs. A producer pushes operation words into a small FIFO. The block issues at most one word per clock to the ALU, then captures the ALU's r/of a fixed number of edges later as a tagged result. This decouples bursty command producers from the ALU and gives a clean result-valid strobe downstream.

---
 rtl/alu_cmd_issue.sv | 152 +++++++++++++++
 tb/tb_alu_cmd_issue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issue.sv
// Command-issue stage for the 4-bit ALU: a command FIFO, a registered issue port and tagged result capture.
// Optional feature macro ALU_CMD_OFCNT_EN adds of_count, a saturating count of captured results with res_of=1.
module alu_cmd_issue #(
  parameter int DEPTH   = 8,
  parameter int ALU_LAT = 2,
  parameter int TAG_W   = 3
) (
  input  logic                   Clk,
  input  logic                   nReset,
  input  logic                   push,
  input  logic [3:0]             push_a,
  input  logic [3:0]             push_b,
  input  logic                   push_cin,
  input  logic [3:0]             push_m,
  input  logic                   hold,
  input  logic                   clr_err,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [3:0]             a,
  output logic [3:0]             b,
  output logic                   cin,
  output logic [3:0]             m,
  output logic                   issue_valid,
  input  logic [3:0]             r_in,
  input  logic                   of_in,
  output logic                   res_valid,
  output logic [3:0]             res_data,
  output logic                   res_of,
  output logic [TAG_W-1:0]       res_tag,
`ifdef ALU_CMD_OFCNT_EN
  output logic [7:0]             of_count,
`endif
  output logic                   drop_err,
  output logic                   mode_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] m;
  } cmd_t;

  cmd_t             mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, do_issue, drop_ev, mode_ev, capture;
  cmd_t             head;

  cmd_t             cmd_q;
  logic             issue_valid_q;
  logic [TAG_W-1:0] tag_q;

  logic [ALU_LAT-1:0] pv_q;
  logic [TAG_W-1:0]   pt_q [ALU_LAT];

  logic             res_valid_q, res_of_q;
  logic [3:0]       res_data_q;
  logic [TAG_W-1:0] res_tag_q;
  logic             drop_err_q, mode_err_q, drop_err_d, mode_err_d;

  // full is taken before the pop, so a push into a full FIFO is dropped even while issuing
  always_comb begin
    full       = (count_q == CW'(DEPTH));
    empty      = (count_q == '0);
    drop_ev    = push & full;
    mode_ev    = push & push_m[3];
    push_ok    = push & ~full & ~push_m[3];
    do_issue   = ~empty & ~hold;
    count_d    = count_q + CW'(push_ok) - CW'(do_issue);
    head       = mem_q[rd_ptr_q];
    capture    = pv_q[ALU_LAT-1];
    drop_err_d = drop_ev | (drop_err_q & ~clr_err);
    mode_err_d = mode_ev | (mode_err_q & ~clr_err);
  end

  always_ff @(posedge Clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {push_a, push_b, push_cin, push_m};
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      cmd_q         <= '0;
      issue_valid_q <= 1'b0;
      tag_q         <= '0;
      pv_q          <= '0;
      for (int i = 0; i < ALU_LAT; i++) pt_q[i] <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_of_q      <= 1'b0;
      res_tag_q     <= '0;
      drop_err_q    <= 1'b0;
      mode_err_q    <= 1'b0;
    end else begin
      count_q       <= count_d;
      issue_valid_q <= do_issue;
      drop_err_q    <= drop_err_d;
      mode_err_q    <= mode_err_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_issue) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        cmd_q    <= head;
        tag_q    <= tag_q + TAG_W'(1);
      end
      // stage 0 is loaded on the issue edge; the last stage marks the capture edge
      pv_q[0] <= do_issue;
      pt_q[0] <= tag_q;
      for (int i = 1; i < ALU_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pt_q[i] <= pt_q[i-1];
      end
      res_valid_q <= capture;
      if (capture) begin
        res_data_q <= r_in;
        res_of_q   <= of_in;
        res_tag_q  <= pt_q[ALU_LAT-1];
      end
    end
  end

`ifdef ALU_CMD_OFCNT_EN
  logic [7:0] ofcnt_q, ofcnt_base;
  always_comb ofcnt_base = clr_err ? 8'd0 : ofcnt_q;
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) ofcnt_q <= 8'd0;
    else if (capture && of_in && ofcnt_base != 8'hFF) ofcnt_q <= ofcnt_base + 8'd1;
    else ofcnt_q <= ofcnt_base;
  end
  assign of_count = ofcnt_q;
`endif

  assign count       = count_q;
  assign a           = cmd_q.a;
  assign b           = cmd_q.b;
  assign cin         = cmd_q.cin;
  assign m           = cmd_q.m;
  assign issue_valid = issue_valid_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_of      = res_of_q;
  assign res_tag     = res_tag_q;
  assign drop_err    = drop_err_q;
  assign mode_err    = mode_err_q;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Randomized bench for alu_cmd_issue against a queue-based reference model, with a 2-edge ALU stub.
module tb_alu_cmd_issue;
  localparam int DEPTH   = 8;
  localparam int ALU_LAT = 2;
  localparam int TAG_W   = 3;

  logic Clk, nReset;
  logic push, push_cin, hold, clr_err;
  logic [3:0] push_a, push_b, push_m;
  logic full, empty, cin, issue_valid, of_in, res_valid, res_of, drop_err, mode_err;
  logic [$clog2(DEPTH):0] count;
  logic [3:0] a, b, m, r_in, res_data;
  logic [TAG_W-1:0] res_tag;
`ifdef ALU_CMD_OFCNT_EN
  logic [7:0] of_count;
`endif

  alu_cmd_issue #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .TAG_W(TAG_W)) dut (
    .Clk(Clk), .nReset(nReset), .push(push), .push_a(push_a), .push_b(push_b),
    .push_cin(push_cin), .push_m(push_m), .hold(hold), .clr_err(clr_err),
    .full(full), .empty(empty), .count(count), .a(a), .b(b), .cin(cin), .m(m),
    .issue_valid(issue_valid), .r_in(r_in), .of_in(of_in), .res_valid(res_valid),
    .res_data(res_data), .res_of(res_of), .res_tag(res_tag),
`ifdef ALU_CMD_OFCNT_EN
    .of_count(of_count),
`endif
    .drop_err(drop_err), .mode_err(mode_err));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [4:0] alu_f(logic [3:0] fa, logic [3:0] fb, logic fc, logic [3:0] fm);
    case (fm)
      4'd0: return {1'b0, fa} + {1'b0, fb} + {4'b0, fc};
      4'd1: return {1'b0, fa} - {1'b0, fb} - {4'b0, fc};
      4'd2: return {1'b0, fa} - {1'b0, fb};
      4'd3: return {1'b0, fa & fb};
      4'd4: return {1'b0, fa | fb};
      4'd5: return {1'b0, ~fa};
      4'd6: return {1'b0, fa} + 5'd1;
      default: return {1'b0, fa} - 5'd1;
    endcase
  endfunction

  // ALU stub: result for the operands present after edge k appears on r_in after edge k+1
  logic [4:0] alu_q;
  always @(posedge Clk) alu_q <= alu_f(a, b, cin, m);
  assign r_in  = alu_q[3:0];
  assign of_in = alu_q[4];

  typedef struct packed { logic [3:0] a; logic [3:0] b; logic cin; logic [3:0] m; } cmd_t;
  typedef struct { int due; int tag; cmd_t c; } sched_t;

  cmd_t   mq[$];
  sched_t sq[$];
  int cyc, m_tag, m_ofc;
  logic m_iv, m_rv, m_rof, m_drop, m_mode, m_cin;
  logic [3:0] m_a, m_b, m_m, m_rdata;
  int m_rtag;
  int n_checks = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete(); sq.delete();
    m_tag = 0; m_ofc = 0; m_iv = 0; m_rv = 0; m_rof = 0; m_drop = 0; m_mode = 0;
    m_a = 0; m_b = 0; m_cin = 0; m_m = 0; m_rdata = 0; m_rtag = 0;
  endtask

  task automatic model_update();
    bit full_pre, iss;
    cmd_t c;
    sched_t s;
    logic [4:0] r5;
    if (!nReset) begin model_reset(); return; end
    cyc++;
    full_pre = (mq.size() == DEPTH);
    iss = (mq.size() != 0) && !hold;
    m_rv = 0;
    if (sq.size() != 0 && sq[0].due == cyc) begin
      s = sq.pop_front();
      r5 = alu_f(s.c.a, s.c.b, s.c.cin, s.c.m);
      m_rv = 1; m_rdata = r5[3:0]; m_rof = r5[4]; m_rtag = s.tag;
    end
    if (clr_err) m_ofc = 0;
    if (m_rv && m_rof && m_ofc < 255) m_ofc++;
    if (iss) begin
      c = mq.pop_front();
      m_a = c.a; m_b = c.b; m_cin = c.cin; m_m = c.m; m_iv = 1;
      sq.push_back('{due: cyc + ALU_LAT, tag: m_tag, c: c});
      m_tag = (m_tag + 1) % (1 << TAG_W);
    end else m_iv = 0;
    if (push && !full_pre && push_m <= 7) mq.push_back({push_a, push_b, push_cin, push_m});
    m_drop = (push && full_pre) ? 1'b1 : (clr_err ? 1'b0 : m_drop);
    m_mode = (push && push_m > 7) ? 1'b1 : (clr_err ? 1'b0 : m_mode);
  endtask

  task automatic check_all();
    chk("full", full, mq.size() == DEPTH);
    chk("empty", empty, mq.size() == 0);
    chk("count", count, mq.size());
    chk("issue_valid", issue_valid, m_iv);
    chk("a", a, m_a);
    chk("b", b, m_b);
    chk("cin", cin, m_cin);
    chk("m", m, m_m);
    chk("res_valid", res_valid, m_rv);
    chk("res_data", res_data, m_rdata);
    chk("res_of", res_of, m_rof);
    chk("res_tag", res_tag, m_rtag);
    chk("drop_err", drop_err, m_drop);
    chk("mode_err", mode_err, m_mode);
`ifdef ALU_CMD_OFCNT_EN
    chk("of_count", of_count, m_ofc);
`endif
  endtask

  task automatic cycle();
    @(posedge Clk); model_update();
    @(negedge Clk); check_all();
  endtask

  task automatic set_push(input logic p, input logic [3:0] pa, input logic [3:0] pb,
                          input logic pc, input logic [3:0] pm);
    push = p; push_a = pa; push_b = pb; push_cin = pc; push_m = pm;
  endtask

  task automatic async_reset();
    #2 nReset = 1'b0;
    #1 model_reset(); check_all();
    chk("rst_res_valid", res_valid, 0);
    chk("rst_count", count, 0);
    @(posedge Clk); model_update();
    @(negedge Clk); check_all();
    nReset = 1'b1;
  endtask

  initial begin
    logic [3:0] pm;
    cyc = 0;
    nReset = 1'b1; hold = 0; clr_err = 0;
    set_push(0, 0, 0, 0, 0);
    model_reset();
    #1 nReset = 1'b0;
    #1 check_all();
    @(negedge Clk); nReset = 1'b1;

    set_push(1, 4'hF, 4'h1, 0, 4'd0); cycle();
    set_push(0, 0, 0, 0, 0); cycle();
    chk("tp1_iv", issue_valid, 1); chk("tp1_a", a, 4'hF); chk("tp1_b", b, 4'h1);
    cycle(); cycle();
    chk("tp1_rv", res_valid, 1); chk("tp1_rd", res_data, 4'h0);
    chk("tp1_rof", res_of, 1); chk("tp1_tag", res_tag, 0);
    repeat (4) cycle();

    set_push(1, 4'd3, 4'd4, 0, 4'd0); cycle();
    set_push(1, 4'd9, 4'd2, 1, 4'd1); cycle();
    set_push(1, 4'hC, 4'hA, 0, 4'd3); cycle();
    set_push(0, 0, 0, 0, 0);
    repeat (8) cycle();

    hold = 1;
    for (int i = 0; i < 8; i++) begin
      set_push(1, 4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom % 8)); cycle();
    end
    chk("tp_full", full, 1); chk("tp_count8", count, 8);
    set_push(1, 4'h5, 4'h5, 0, 4'd0); cycle();
    chk("tp_drop", drop_err, 1); chk("tp_count8b", count, 8);
    set_push(0, 0, 0, 0, 0); clr_err = 1; cycle();
    clr_err = 0; hold = 0;
    set_push(1, 4'h7, 4'h2, 0, 4'd4); cycle();
    chk("tp_count7", count, 7); chk("tp_drop2", drop_err, 1);
    set_push(0, 0, 0, 0, 0); clr_err = 1; cycle();
    chk("tp_drop_clr", drop_err, 0);
    clr_err = 0;
    repeat (12) cycle();
    chk("tp_empty", empty, 1);

    set_push(1, 4'h3, 4'h3, 0, 4'hA); cycle();
    chk("tp_mode", mode_err, 1); chk("tp_mode_cnt", count, 0);
    set_push(0, 0, 0, 0, 0); cycle();
    chk("tp_mode_noiss", issue_valid, 0);
    clr_err = 1; cycle(); clr_err = 0;

    for (int i = 0; i < 1500; i++) begin
      pm = ($urandom % 10 == 0) ? 4'(8 + $urandom % 8) : 4'($urandom % 8);
      set_push(1'($urandom % 3 != 0), 4'($urandom), 4'($urandom), 1'($urandom), pm);
      hold = ($urandom % 4 == 0);
      clr_err = ($urandom % 16 == 0);
      if (i == 700) async_reset();
      else cycle();
    end
    set_push(0, 0, 0, 0, 0); hold = 0; clr_err = 0;
    repeat (12) cycle();

    for (int i = 0; i < 300; i++) begin
      set_push(1, 4'hF, 4'h1, 0, 4'd0); cycle();
    end
    set_push(0, 0, 0, 0, 0);
    repeat (6) cycle();
`ifdef ALU_CMD_OFCNT_EN
    chk("tp_ofcnt_sat", of_count, 255);
`endif

    for (int i = 0; i < 4; i++) begin
      set_push(1, 4'(i), 4'(i + 1), 0, 4'd0); cycle();
    end
    set_push(0, 0, 0, 0, 0);
    async_reset();
    repeat (10) cycle();
    chk("tp_rst_norv", res_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
